sram_req_adapter: RTL and testbench

- Upstream stage for the single-port sky130 SRAM wrapper (32x512, byte write masks, 1-cycle read latency).
- Converts a valid/ready request channel into the wrapper's req/write/addr/wdata/wmask strobes.
- Tracks the fixed read latency and buffers responses in a small FIFO, so the response channel can apply backpressure without losing SRAM read data.
- Sits between the bus-side device port (TL-UL adapter) and the RAM wrapper.

---
 rtl/sram_req_adapter.sv | 127 ++++++++++++
 tb/tb_sram_req_adapter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_req_adapter: valid/ready requests to single-port SRAM strobes |
// | with fixed read-latency tracking and a credit-managed response FIFO.|
// | Optional feature macro: SRAM_REQ_ADAPTER_ERR_EN (address checking). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sram_req_adapter #(
  parameter int  WIDTH     = 32,
  parameter int  DEPTH     = 512,
  parameter int  RSP_DEPTH = 2,
  localparam int c_AW      = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [31:0]      req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  input  logic [3:0]       req_be_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_write_o,
  output logic             rsp_err_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [c_AW-1:0]  ram_addr_o,
  output logic [WIDTH-1:0] ram_wdata_o,
  output logic [WIDTH-1:0] ram_wmask_o,
  input  logic [WIDTH-1:0] ram_rdata_i
);

  localparam int c_CW = $clog2(RSP_DEPTH + 1);
  localparam int c_PW = $clog2(RSP_DEPTH);

  logic             w_credit_ok;
  logic             w_ready;
  logic             w_take;
  logic             w_pop;
  logic             w_push;
  logic             w_err_now;
  logic [c_CW:0]    w_credit;
  logic [WIDTH-1:0] w_push_rdata;
  logic [WIDTH+1:0] w_head;

  logic             pend_q;
  logic             pend_write_q;
  logic             pend_err_q;
  logic [c_CW-1:0]  count_q, count_d;
  logic [c_PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WIDTH+1:0] fifo_mem_q [RSP_DEPTH];

`ifdef SRAM_REQ_ADAPTER_ERR_EN
  assign w_err_now = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= 30'(DEPTH));
  assign rsp_err_o = w_head[0];
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{req_addr_i[31:c_AW+2], req_addr_i[1:0], w_head[0]};
  assign w_err_now     = 1'b0;
  assign rsp_err_o     = 1'b0;
`endif

  // Credits count FIFO entries plus the read still in flight; a same-cycle
  // pop frees one, which is what allows full throughput with two entries.
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign w_credit    = {1'b0, count_q} + {{c_CW{1'b0}}, pend_q} - {{c_CW{1'b0}}, w_pop};
  assign w_credit_ok = w_credit < (c_CW + 1)'(RSP_DEPTH);
  assign w_ready     = !rst_i && w_credit_ok;
  assign w_take      = req_valid_i && w_credit_ok;
  assign req_ready_o = w_ready;

  assign ram_req_o   = req_valid_i && w_ready && !w_err_now;
  assign ram_write_o = req_write_i;
  assign ram_addr_o  = req_addr_i[c_AW+1:2];
  assign ram_wdata_o = req_wdata_i;

  for (genvar i = 0; i < WIDTH / 8; i++) begin : g_wmask
    assign ram_wmask_o[8*i +: 8] = {8{req_be_i[i]}};
  end

  assign w_push       = pend_q;
  assign w_push_rdata = (!pend_write_q && !pend_err_q) ? ram_rdata_i : '0;

  assign w_head      = fifo_mem_q[rd_ptr_q];
  assign rsp_valid_o = count_q != '0;
  assign rsp_rdata_o = w_head[WIDTH+1:2];
  assign rsp_write_o = w_head[1];

  always_comb begin
    count_d  = count_q + c_CW'(w_push) - c_CW'(w_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) wr_ptr_d = (wr_ptr_q == c_PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + c_PW'(1);
    if (w_pop)  rd_ptr_d = (rd_ptr_q == c_PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + c_PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q       <= 1'b0;
      pend_write_q <= 1'b0;
      pend_err_q   <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      pend_q       <= w_take;
      pend_write_q <= req_write_i;
      pend_err_q   <= w_err_now;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; validity lives entirely in count_q.
  always_ff @(posedge clk_i) begin
    if (w_push) fifo_mem_q[wr_ptr_q] <= {w_push_rdata, pend_write_q, pend_err_q};
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && count_q == c_CW'(RSP_DEPTH) && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_sram_req_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sram_req_adapter: directed vectors plus multi-cycle sequences    |
// | against a behavioural SRAM model.                                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sram_req_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_req, ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata, ram_wmask, ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [512];

  initial forever #5 clk = ~clk;

  sram_req_adapter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_write_o(rsp_write), .rsp_err_o(rsp_err),
    .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata)
  );

  // Behavioural SRAM: byte-masked writes, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else           ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        rr;
    logic        e_rdy;
    logic        e_rq;
    logic [31:0] e_wm;
    logic        e_rv;
    logic        e_rw;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic rr);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be; rsp_ready = rr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string name, input logic [31:0] rd, input logic wr, input logic er);
    check({name, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({name, ".rsp_rdata"}, rsp_rdata, rd);
    check({name, ".rsp_write"}, {31'd0, rsp_write}, {31'd0, wr});
    check({name, ".rsp_err"},   {31'd0, rsp_err},   {31'd0, er});
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    ram_rdata = 32'h0;

    //          v  w  addr        wdata          be    rr  rdy rq  wmask          rv rw rdata
    tbl[0]  = '{1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 32'h0};
    tbl[1]  = '{1, 0, 32'h10, 32'h0,        4'h0, 1, 1, 1, 32'h0,        0, 0, 32'h0};
    tbl[2]  = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 1, 0, 32'h0,        1, 1, 32'h0};
    tbl[3]  = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 1, 0, 32'h0,        1, 0, 32'hDEADBEEF};
    tbl[4]  = '{1, 1, 32'h20, 32'h11223344, 4'hF, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 32'h0};
    tbl[5]  = '{1, 1, 32'h20, 32'hAABBCCDD, 4'h5, 1, 1, 1, 32'h00FF00FF, 0, 0, 32'h0};
    tbl[6]  = '{1, 0, 32'h20, 32'h0,        4'h0, 1, 1, 1, 32'h0,        1, 1, 32'h0};
    tbl[7]  = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 1, 0, 32'h0,        1, 1, 32'h0};
    tbl[8]  = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 1, 0, 32'h0,        1, 0, 32'h11BB33DD};
    tbl[9]  = '{1, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 1, 1, 1, 32'h0,        0, 0, 32'h0};
    tbl[10] = '{1, 0, 32'h20, 32'h0,        4'h0, 1, 1, 1, 32'h0,        0, 0, 32'h0};
    tbl[11] = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 1, 0, 32'h0,        1, 1, 32'h0};
    tbl[12] = '{0, 0, 32'h0,  32'h0,        4'h0, 1, 1, 0, 32'h0,        1, 0, 32'h11BB33DD};

    // Reset state, with a request presented so ready/req are meaningful.
    rst = 1'b1;
    drive(1, 0, 32'h0, 32'h0, 4'h0, 1);
    check("reset.req_ready", {31'd0, req_ready}, 32'd0);
    check("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset.ram_req",   {31'd0, ram_req},   32'd0);
    step(); step();
    rst = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1);
    check("post_reset.req_ready", {31'd0, req_ready}, 32'd1);
    step();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].rr);
      check($sformatf("vec%0d.req_ready", i), {31'd0, req_ready}, {31'd0, tbl[i].e_rdy});
      check($sformatf("vec%0d.ram_req", i),   {31'd0, ram_req},   {31'd0, tbl[i].e_rq});
      check($sformatf("vec%0d.wmask", i),     ram_wmask,          tbl[i].e_wm);
      check($sformatf("vec%0d.rsp_valid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].e_rv});
      if (tbl[i].e_rv) check_rsp($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_rw, 1'b0);
      step();
    end

    // Throughput: 8 writes then 8 reads back to back, responses from cycle 2.
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drive(1, c < 8, 32'((c % 8) * 4), 32'hA5000000 + 32'(c % 8), 4'hF, 1);
      else        drive(0, 0, 32'h0, 32'h0, 4'h0, 1);
      if (c < 16) begin
        check($sformatf("tput%0d.req_ready", c), {31'd0, req_ready}, 32'd1);
        check($sformatf("tput%0d.ram_req", c),   {31'd0, ram_req},   32'd1);
      end
      if (c < 2) check($sformatf("tput%0d.rsp_valid", c), {31'd0, rsp_valid}, 32'd0);
      else if (c < 10) check_rsp($sformatf("tput%0d", c), 32'h0, 1'b1, 1'b0);
      else check_rsp($sformatf("tput%0d", c), 32'hA5000000 + 32'(c - 10), 1'b0, 1'b0);
      step();
    end
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1);
    check("tput_end.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();

    // Backpressure: two reads accepted, then stall with held head.
    for (int c = 0; c < 9; c++) begin
      case (c)
        0:       drive(1, 0, 32'h0, 32'h0, 4'h0, 0);
        1:       drive(1, 0, 32'h4, 32'h0, 4'h0, 0);
        2, 3, 4: drive(1, 0, 32'h8, 32'h0, 4'h0, 0);
        5:       drive(1, 0, 32'h8, 32'h0, 4'h0, 1);
        default: drive(0, 0, 32'h0, 32'h0, 4'h0, 1);
      endcase
      if (c <= 1) begin
        check($sformatf("bp%0d.req_ready", c), {31'd0, req_ready}, 32'd1);
        check($sformatf("bp%0d.rsp_valid", c), {31'd0, rsp_valid}, 32'd0);
      end else if (c <= 4) begin
        check($sformatf("bp%0d.req_ready", c), {31'd0, req_ready}, 32'd0);
        check($sformatf("bp%0d.ram_req", c),   {31'd0, ram_req},   32'd0);
        check_rsp($sformatf("bp%0d", c), 32'hA5000000, 1'b0, 1'b0);
      end else if (c == 5) begin
        check("bp5.req_ready", {31'd0, req_ready}, 32'd1);
        check_rsp("bp5", 32'hA5000000, 1'b0, 1'b0);
      end else if (c <= 7) begin
        check_rsp($sformatf("bp%0d", c), 32'hA5000000 + 32'(c - 5), 1'b0, 1'b0);
      end else begin
        check("bp8.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end
      step();
    end

`ifdef SRAM_REQ_ADAPTER_ERR_EN
    drive(1, 0, 32'h802, 32'h0, 4'h0, 1);
    check("err0.req_ready", {31'd0, req_ready}, 32'd1);
    check("err0.ram_req",   {31'd0, ram_req},   32'd0);
    step();
    drive(1, 0, 32'h800, 32'h0, 4'h0, 1);
    check("err1.ram_req", {31'd0, ram_req}, 32'd0);
    step();
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1);
    check_rsp("err2", 32'h0, 1'b0, 1'b1);
    step();
    check_rsp("err3", 32'h0, 1'b0, 1'b1);
    step();
    check("err4.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
`else
    drive(1, 0, 32'h800, 32'h0, 4'h0, 1);
    check("alias0.ram_req",  {31'd0, ram_req}, 32'd1);
    check("alias0.ram_addr", {23'd0, ram_addr}, 32'd0);
    step();
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1);
    check("alias1.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    check_rsp("alias2", 32'hA5000000, 1'b0, 1'b0);
    step();
    check("alias3.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
`endif

    // Reset in the cycle after an accepted read: nothing must survive.
    drive(1, 0, 32'h4, 32'h0, 4'h0, 1);
    check("rstmid0.ram_req", {31'd0, ram_req}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("rstmid1.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstmid1.req_ready", {31'd0, req_ready}, 32'd0);
    check("rstmid1.ram_req",   {31'd0, ram_req},   32'd0);
    step();
    check("rstmid2.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    rst = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 4'h0, 1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rstmid_after%0d.rsp_valid", c), {31'd0, rsp_valid}, 32'd0);
      check($sformatf("rstmid_after%0d.req_ready", c), {31'd0, req_ready}, 32'd1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
